// File: rtl/reg_wb_buffer.sv
// rtl/reg_wb_buffer.sv - in-order writeback queue with read bypass; REG_WB_COALESCE_EN merges same-address pushes
module reg_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       wb_stall,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_addr,
    output logic [DW-1:0]              wr_data,
    input  logic [AW-1:0]              rd_addr1,
    input  logic [AW-1:0]              rd_addr2,
    output logic                       byp_hit1,
    output logic [DW-1:0]              byp_data1,
    output logic                       byp_hit2,
    output logic [DW-1:0]              byp_data2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_prev;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          coalesce;
    logic          alloc;
    logic          pop;

    assign count     = cnt;
    assign empty     = (cnt == '0);
    assign in_ready  = (cnt < CW'(DEPTH));
    assign wr_en     = !empty && !wb_stall;
    assign pop       = wr_en;
    // Memories are not reset, so the write port is forced to zero while empty
    assign wr_addr   = empty ? '0 : addr_mem[head];
    assign wr_data   = empty ? '0 : data_mem[head];
    assign tail_prev = tail - 1'b1;
    // x0 requests complete the handshake but never occupy an entry
    assign accept    = in_valid && in_ready && (in_addr != '0);

`ifdef REG_WB_COALESCE_EN
    // The youngest entry may only be merged into if it is not leaving this cycle
    assign coalesce = accept && !empty && (addr_mem[tail_prev] == in_addr) &&
                      !(pop && (cnt == CW'(1)));
`else
    assign coalesce = 1'b0;
`endif
    assign alloc = accept && !coalesce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (alloc) tail <= tail + 1'b1;
            if (pop)   head <= head + 1'b1;
            case ({alloc, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end else if (coalesce) begin
            data_mem[tail_prev] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match wins
    always_comb begin
        logic [PW-1:0] idx;
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < cnt) begin
                if ((rd_addr1 != '0) && (addr_mem[idx] == rd_addr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_mem[idx];
                end
                if ((rd_addr2 != '0) && (addr_mem[idx] == rd_addr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_mem[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_wb_buffer.sv
// tb/tb_reg_wb_buffer.sv - randomized scoreboard bench for reg_wb_buffer
module tb_reg_wb_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          wb_stall = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic          byp_hit1;
    logic [DW-1:0] byp_data1;
    logic          byp_hit2;
    logic [DW-1:0] byp_data2;
    logic [2:0]    count;
    logic          empty;

    always #5 clk = ~clk;

    reg_wb_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .wb_stall(wb_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .count(count), .empty(empty)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t pend[$];
    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic          cur_v  = 1'b0;
    logic [AW-1:0] cur_a  = '0;
    logic [DW-1:0] cur_d  = '0;
    logic          cur_st = 1'b0;
    bit            will_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: pending writes as a plain list, oldest first
    task automatic model_edge();
        bit   pop;
        bit   acc;
        bit   merged;
        ent_t e;
        pop    = (pend.size() > 0) && !cur_st;
        acc    = cur_v && (pend.size() < DEPTH) && (cur_a != 0);
        merged = 1'b0;
`ifdef REG_WB_COALESCE_EN
        if (acc && pend.size() > 0 && pend[pend.size()-1].a == cur_a &&
            !(pop && pend.size() == 1)) begin
            e = pend[pend.size()-1];
            e.d = cur_d;
            pend[pend.size()-1] = e;
            merged = 1'b1;
        end
`endif
        if (pop) void'(pend.pop_front());
        if (acc && !merged) begin
            e.a = cur_a;
            e.d = cur_d;
            pend.push_back(e);
        end
    endtask

    task automatic byp_exp(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (ra != 0) begin
            foreach (pend[i]) begin
                if (pend[i].a == ra) begin
                    h = 1'b1;
                    d = pend[i].d;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic          h;
        logic [DW-1:0] d;
        chk("count", count, pend.size());
        chk("empty", empty, pend.size() == 0);
        chk("in_ready", in_ready, pend.size() < DEPTH);
        byp_exp(rd_addr1, h, d);
        chk("byp_hit1", byp_hit1, h);
        chk("byp_data1", byp_data1, d);
        byp_exp(rd_addr2, h, d);
        chk("byp_hit2", byp_hit2, h);
        chk("byp_data2", byp_data2, d);
    endtask

    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic st, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(posedge clk);
        #1;
        model_edge();
        in_valid = v; in_addr = a; in_data = d; wb_stall = st;
        rd_addr1 = r1; rd_addr2 = r2;
        cur_v = v; cur_a = a; cur_d = d; cur_st = st;
        will_acc = v && (pend.size() < DEPTH);
        if (pend.size() > 0 && !st) exp_q.push_back(pend[0]);
        #1;
        check_outputs();
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        in_valid = 1'b0;
        cur_v = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_byp_hit1", byp_hit1, 0);
        pend.delete();
        exp_q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        ent_t e;
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                end
            end else if (exp_q.size() > 0) begin
                chk("missing_write", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          st;
        bit            held;

        repeat (2) @(posedge clk);
        #1;
        chk("init_count", count, 0);
        chk("init_wr_en", wr_en, 0);
        chk("init_wr_addr", wr_addr, 0);
        chk("init_wr_data", wr_data, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_empty", empty, 1);
        chk("init_byp_data2", byp_data2, 0);
        rst_n = 1'b1;

        // single write and x0 drop
        cycle(1, 5, 32'hDEAD_BEEF, 0, 5, 0);
        cycle(0, 0, 0, 0, 5, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'h1234, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // async reset with three entries pending
        cycle(1, 3, 32'h33, 1, 3, 0);
        cycle(1, 4, 32'h44, 1, 4, 3);
        cycle(1, 6, 32'h66, 1, 6, 4);
        cycle(0, 0, 0, 1, 3, 6);
        reset_mid();
        cycle(0, 0, 0, 0, 3, 6);

        // fill under stall, fifth request held until space frees
        for (int i = 0; i < 4; i++) cycle(1, AW'(10 + i), 32'h100 + i, 1, AW'(10 + i), 11);
        held = 1'b1;
        for (int k = 0; k < 12 && held; k++) begin
            cycle(1, 14, 32'h104, (k < 3), 14, 10);
            if (will_acc) held = 1'b0;
        end
        chk("fifth_accept_timeout", held, 0);
        cycle(0, 0, 0, 0, 14, 0);

        // duplicate address: youngest value bypassed, x0 never hits
        cycle(1, 7, 32'hA, 1, 7, 0);
        cycle(1, 7, 32'hB, 1, 7, 0);
        cycle(0, 0, 0, 1, 7, 0);
        cycle(1, 9, 32'h1, 1, 9, 7);
        cycle(1, 9, 32'h2, 1, 9, 7);
        cycle(0, 0, 0, 1, 9, 7);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 9, 7);

        // randomized traffic, refused requests held by the source
        v = 0; a = 0; d = 0; held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                v = ($urandom_range(3) != 0);
                a = AW'($urandom_range(7));
                d = $urandom;
            end
            st = (n % 100 < 30) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            cycle(v, a, d, st, AW'($urandom_range(7)), AW'($urandom_range(7)));
            held = v && !will_acc;
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
